// File: rtl/random_scheduler_pkg.sv
// Shared types and constants for the random-word scheduler and the LFSR generator it serves.
package random_scheduler_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    READY = 2'd1,
    ISSUE = 2'd2
  } state_t;

  localparam int REFRESH_DEF = 16;
  localparam int RAND_W      = 16;

endpackage

// File: rtl/random_scheduler_rr_pick.sv
// Combinational round-robin selector: searches req starting one past last and
// returns the one-hot winner and its index.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int c;
      c = (int'(last) + k) % NUM_REQ;
      if (!found && req[c]) begin
        found    = 1'b1;
        grant[c] = 1'b1;
        idx      = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/random_scheduler.sv
// Hands out non-overlapping windows of the shared LFSR to NUM_REQ clients, round-robin.
// Optional per-client AND mask on the issued word: define RANDOM_SCHED_MASK_EN.
module random_scheduler
  import random_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int REFRESH = REFRESH_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [RAND_W-1:0]          random,
  input  logic [NUM_REQ-1:0]         req,
`ifdef RANDOM_SCHED_MASK_EN
  input  logic [NUM_REQ*RAND_W-1:0]  reqMask,
`endif
  output logic [NUM_REQ-1:0]         ack,
  output logic [RAND_W-1:0]          randOut,
  output logic                       fresh
);

  localparam int CNT_W = $clog2(REFRESH) + 1;
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_RESET = IDX_W'(NUM_REQ - 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [IDX_W-1:0]   last_grant;
  logic [NUM_REQ-1:0] win_grant;
  logic [IDX_W-1:0]   win_idx;
  logic               take;
  logic [RAND_W-1:0]  word_p0;

  function automatic logic [RAND_W-1:0] apply_mask(input logic [RAND_W-1:0] sample,
                                                   input logic [RAND_W-1:0] mask);
    return sample & mask;
  endfunction

  rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr_pick (
    .req   (req),
    .last  (last_grant),
    .grant (win_grant),
    .idx   (win_idx)
  );

  assign take = (state == READY) && (|req);

`ifdef RANDOM_SCHED_MASK_EN
  assign word_p0 = apply_mask(random, reqMask[int'(win_idx)*RAND_W +: RAND_W]);
`else
  assign word_p0 = random;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      FILL: begin
        if (cnt == CNT_LAST) begin
          state_nxt = READY;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      READY: begin
        if (|req) state_nxt = ISSUE;
      end
      ISSUE: begin
        // The ISSUE clock already shifts in a fresh bit, so it counts as the
        // first clock of the next window; this gives REFRESH+1 clocks per grant.
        if (CNT_LAST == '0) begin
          state_nxt = READY;
          cnt_nxt   = '0;
        end else begin
          state_nxt = FILL;
          cnt_nxt   = CNT_ONE;
        end
      end
      default: begin
        state_nxt = FILL;
        cnt_nxt   = '0;
      end
    endcase
  end

  // p0 -> p1: grant edge registers the word, the one-cycle ack and the new owner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FILL;
      cnt        <= '0;
      ack        <= '0;
      randOut    <= '0;
      fresh      <= 1'b0;
      last_grant <= IDX_RESET;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      fresh <= (state_nxt == READY);
      ack   <= take ? win_grant : '0;
      if (take) begin
        randOut    <= word_p0;
        last_grant <= win_idx;
      end
    end
  end

endmodule
